// File: rtl/sample_buffer.sv
// sample_buffer: assembles little-endian 24-bit samples from a UART byte stream
// into a FIFO. An I2S driver pops the FIFO one word at a time.
//
// Parameters
//   DEPTH      : FIFO depth in samples (power of two, >= 4)
//   GAP_CYCLES : idle clocks after which a partially received sample is dropped
//
// Ports
//   clk, rst_n  : system clock (rising edge), asynchronous active-low reset
//   byte_in     : received UART byte, valid while byte_ready is high
//   byte_ready  : single-cycle strobe for byte_in
//   sample_req  : single-cycle strobe from the I2S driver at each word boundary
//   mono_sample : registered sample presented to the I2S driver
//   fill_level  : FIFO occupancy (0..DEPTH)
//   full, empty : occupancy flags derived from the registered pointers
//   overflow    : sticky, set when a completed sample is dropped
//   underrun    : one-cycle pulse when sample_req finds the FIFO empty in PLAY
//   playing     : high while the state machine is in PLAY
//
// Optional feature: define SAMPLE_BUFFER_UNDERRUN_HOLD_EN to hold mono_sample on
// underrun instead of loading 0.
module sample_buffer #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned GAP_CYCLES = 2700,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned GW        = $clog2(GAP_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    byte_in,
  input  logic          byte_ready,
  input  logic          sample_req,
  output logic [23:0]   mono_sample,
  output logic [AW:0]   fill_level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underrun,
  output logic          playing
);

  typedef enum logic {StPrime, StPlay} state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q;
  logic [7:0]    b0_q, b1_q;
  logic [GW-1:0] gap_q;
  logic [23:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [23:0]   mono_q, mono_d;
  logic          overflow_q, underrun_q;
  logic          push, pop, starve, wr_en;

  // Third byte of a sample completes it; it is written on this same edge.
  assign push   = byte_ready && (idx_q == 2'd2);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fill_level = wr_ptr_q - rd_ptr_q;
  assign pop    = sample_req && (state_q == StPlay) && !empty;
  assign starve = sample_req && (state_q == StPlay) && empty;
  // A simultaneous pop frees the slot, so a write to a full FIFO still lands.
  assign wr_en  = push && (!full || pop);

  // Byte assembly with idle-gap resynchronisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
      b0_q  <= 8'd0;
      b1_q  <= 8'd0;
      gap_q <= '0;
    end else if (byte_ready) begin
      gap_q <= '0;
      unique case (idx_q)
        2'd0:    begin b0_q <= byte_in; idx_q <= 2'd1; end
        2'd1:    begin b1_q <= byte_in; idx_q <= 2'd2; end
        default: idx_q <= 2'd0;
      endcase
    end else if (idx_q != 2'd0) begin
      if (gap_q == GW'(GAP_CYCLES - 1)) begin
        idx_q <= 2'd0;
        gap_q <= '0;
      end else begin
        gap_q <= gap_q + 1'b1;
      end
    end
  end

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {byte_in, b1_q, b0_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      mono_q     <= 24'd0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !wr_en) overflow_q <= 1'b1;
      underrun_q <= starve;
      mono_q     <= mono_d;
    end
  end

  // No write-to-read bypass: the head is read from the registered pointers only.
  always_comb begin
    mono_d = mono_q;
    if (sample_req) begin
      if (pop) begin
        mono_d = mem[rd_ptr_q[AW-1:0]];
      end else begin
        mono_d = 24'd0;
`ifdef SAMPLE_BUFFER_UNDERRUN_HOLD_EN
        if (starve) mono_d = mono_q;
`endif
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StPrime;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPrime: if (fill_level >= (AW+1)'(DEPTH / 2)) state_d = StPlay;
      StPlay:  if (starve) state_d = StPrime;
      default: state_d = StPrime;
    endcase
  end

  // Outputs.
  always_comb begin
    playing     = (state_q == StPlay);
    mono_sample = mono_q;
    overflow    = overflow_q;
    underrun    = underrun_q;
  end

endmodule

// File: tb/tb_sample_buffer.sv
module tb_sample_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 20;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    byte_in;
  logic          byte_ready;
  logic          sample_req;
  logic [23:0]   mono_sample;
  logic [AW:0]   fill_level;
  logic          full, empty, overflow, underrun, playing;

  int n_cmp  = 0;
  int n_fail = 0;

  sample_buffer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_ready (byte_ready),
    .sample_req (sample_req),
    .mono_sample(mono_sample),
    .fill_level (fill_level),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underrun   (underrun),
    .playing    (playing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] q[$];      // FIFO contents, head first
  logic [7:0]  part[$];   // bytes of the sample being received
  int          idle;
  logic [23:0] m_mono;
  bit          m_under, m_over, m_play;
  int          pre_fill;
  bit          complete, next_play;
  logic [23:0] samp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); part.delete();
      idle = 0; m_mono = 0; m_under = 0; m_over = 0; m_play = 0;
    end else begin
      pre_fill  = q.size();
      next_play = m_play;
      m_under   = 0;
      complete  = 0;
      if (byte_ready) begin
        part.push_back(byte_in);
        idle = 0;
        if (part.size() == 3) begin
          samp = {part[2], part[1], part[0]};
          part.delete();
          complete = 1;
        end
      end else if (part.size() > 0) begin
        idle++;
        if (idle == GAP) begin
          part.delete();
          idle = 0;
        end
      end
      if (sample_req) begin
        if (!m_play) m_mono = 0;
        else if (q.size() > 0) m_mono = q.pop_front();
        else begin
          m_under   = 1;
          next_play = 0;
`ifndef SAMPLE_BUFFER_UNDERRUN_HOLD_EN
          m_mono = 0;
`endif
        end
      end
      // Any pop above has already made room for this write.
      if (complete) begin
        if (q.size() < DEPTH) q.push_back(samp);
        else m_over = 1;
      end
      if (!m_play && pre_fill >= DEPTH / 2) next_play = 1;
      m_play = next_play;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("mono_sample", 32'(mono_sample), 32'(m_mono));
    chk("fill_level",  32'(fill_level),  32'(q.size()));
    chk("full",        32'(full),        32'(q.size() == DEPTH));
    chk("empty",       32'(empty),       32'(q.size() == 0));
    chk("overflow",    32'(overflow),    32'(m_over));
    chk("underrun",    32'(underrun),    32'(m_under));
    chk("playing",     32'(playing),     32'(m_play));
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 time unit after a rising edge and are held one cycle.
  task automatic tick(input bit br, input logic [7:0] b, input bit sr);
    byte_ready = br;
    byte_in    = b;
    sample_req = sr;
    @(posedge clk);
    #1;
    byte_ready = 1'b0;
    sample_req = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    tick(1, a, 0);
    tick(1, b, 0);
    tick(1, c, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_fill",    32'(fill_level), 0);
    chk("rst_empty",   32'(empty),      1);
    chk("rst_full",    32'(full),       0);
    chk("rst_playing", 32'(playing),    0);
    chk("rst_mono",    32'(mono_sample), 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst_n = 1'b1;
    tick(0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; byte_in = 0; byte_ready = 0; sample_req = 0;
    @(posedge clk); #1;
    do_reset();

    // Little-endian assembly, write latency one cycle.
    tick(1, 8'h56, 0);
    tick(1, 8'h34, 0);
    chk("fill_before_3rd", 32'(fill_level), 0);
    tick(1, 8'h12, 0);
    chk("fill_after_3rd", 32'(fill_level), 1);

    // Partial sample dropped after a full gap.
    tick(1, 8'hAA, 0);
    tick(1, 8'hBB, 0);
    repeat (GAP) tick(0, 0, 0);
    send3(8'h01, 8'h02, 8'h03);
    chk("fill_after_gap", 32'(fill_level), 2);
    tick(0, 0, 0);
    chk("playing_at_half", 32'(playing), 1);

    tick(0, 0, 1);
    chk("read0", 32'(mono_sample), 32'h123456);
    tick(0, 0, 1);
    chk("read1", 32'(mono_sample), 32'h030201);
    chk("empty_after_reads", 32'(empty), 1);

    // Starved request in PLAY.
    tick(0, 0, 1);
    chk("underrun_pulse", 32'(underrun), 1);
    chk("playing_drop",   32'(playing), 0);
`ifdef SAMPLE_BUFFER_UNDERRUN_HOLD_EN
    chk("mono_on_underrun", 32'(mono_sample), 32'h030201);
`else
    chk("mono_on_underrun", 32'(mono_sample), 0);
`endif
    tick(0, 0, 0);
    chk("underrun_single", 32'(underrun), 0);

    // One cycle short of the gap: partial sample survives.
    tick(1, 8'hAA, 0);
    repeat (GAP - 1) tick(0, 0, 0);
    tick(1, 8'h01, 0);
    tick(1, 8'h02, 0);
    chk("fill_gap_minus1", 32'(fill_level), 1);
    tick(0, 0, 0);
    do_reset();

    // Five pushes into a depth-4 FIFO with no reads.
    for (int i = 0; i < 5; i++) send3(8'(i), 8'(i + 16), 8'(i + 32));
    chk("ovf_full",     32'(full), 1);
    chk("ovf_overflow", 32'(overflow), 1);
    chk("ovf_fill",     32'(fill_level), 4);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1);
      chk("ovf_readback", 32'(mono_sample), 32'({8'(i + 32), 8'(i + 16), 8'(i)}));
    end
    tick(0, 0, 1);
    chk("fifth_absent", 32'(underrun), 1);
    do_reset();

    // Push and pop together on a full FIFO.
    for (int i = 0; i < 4; i++) send3(8'(i), 8'h80, 8'h40);
    tick(0, 0, 0);
    chk("full_playing", 32'(playing), 1);
    tick(1, 8'h11, 0);
    tick(1, 8'h22, 0);
    tick(1, 8'h33, 1);
    chk("pp_fill",     32'(fill_level), 4);
    chk("pp_overflow", 32'(overflow), 0);
    chk("pp_mono",     32'(mono_sample), 32'h408000);

    // Randomized traffic with varying byte/request ratios and occasional resets.
    for (int phase = 0; phase < 4; phase++) begin
      int bdiv, rdiv;
      bdiv = 1 + phase;
      rdiv = 3 + 2 * (3 - phase);
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 299) == 0) repeat (GAP - 1 + $urandom_range(0, 2)) tick(0, 0, 0);
        else if ($urandom_range(0, 999) == 0) do_reset();
        else tick(($urandom % bdiv) == 0, 8'($urandom), ($urandom % rdiv) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_buffer.md
SAMPLE_BUFFER -- requirements
Module: sample_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 256: FIFO depth in 24-bit samples, power of two, minimum 4.
REQ-002 The module SHALL have parameter GAP_CYCLES, default 2700: idle clocks (100 us at 27 MHz) after which a partial sample is discarded.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock (27 MHz); all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port byte_in, input, 8 bits: received UART byte.
REQ-006 The module SHALL have port byte_ready, input, 1 bit: single-cycle strobe; byte_in is valid on this cycle.
REQ-007 The module SHALL have port sample_req, input, 1 bit: single-cycle strobe from the I2S driver at each word boundary.
REQ-008 The module SHALL have port mono_sample, output, 24 bits: registered sample presented to the I2S driver.
REQ-009 The module SHALL have port fill_level, output, log2(DEPTH)+1 bits: current FIFO occupancy.
REQ-010 The module SHALL have port full, output, 1 bit: asserted when fill_level equals DEPTH.
REQ-011 The module SHALL have port empty, output, 1 bit: asserted when fill_level equals 0.
REQ-012 The module SHALL have port overflow, output, 1 bit: sticky flag, set when a sample is dropped.
REQ-013 The module SHALL have port underrun, output, 1 bit: single-cycle pulse on each starved sample_req in PLAY.
REQ-014 The module SHALL have port playing, output, 1 bit: high while the state is PLAY.

Function
REQ-015 Byte assembly SHALL be little-endian: byte 0 goes to [7:0], byte 1 to [15:8], byte 2 to [23:16]; a 2-bit index wraps 2->0.
REQ-016 The completed sample SHALL be written to the FIFO on the clock edge after the third byte_ready (write latency 1).
REQ-017 A write while full SHALL be dropped and SHALL set overflow, unless a pop occurs in the same cycle, in which case the write is accepted.
REQ-018 The gap counter SHALL reset on every byte_ready and otherwise increment while index is nonzero; on reaching GAP_CYCLES, index SHALL return to 0 and the partial sample SHALL be discarded.
REQ-019 The state machine SHALL have two states: PRIME and PLAY; reset enters PRIME.
REQ-020 PRIME SHALL transition to PLAY when fill_level is at least DEPTH/2.
REQ-021 In PRIME, sample_req SHALL NOT pop, SHALL NOT pulse underrun, and SHALL load mono_sample with 0.
REQ-022 In PLAY with the FIFO not empty, sample_req SHALL load the head entry into mono_sample on the next edge and pop it (read latency 1).
REQ-023 In PLAY with the FIFO empty, sample_req SHALL pulse underrun for one cycle and return the state to PRIME; mono_sample SHALL follow REQ-029.
REQ-024 There SHALL be no write-to-read bypass: a write and a sample_req in the same cycle on an empty FIFO counts as an underrun.
REQ-025 fill_level SHALL be unchanged when a push and a pop occur in the same cycle; full and empty SHALL be derived from registered pointers with one extra wrap bit.

Reset
REQ-026 While rst_n is low, the following SHALL be held at 0: mono_sample, pointers, fill_level, byte index, gap counter, overflow, underrun, and playing.
REQ-027 While rst_n is low, empty SHALL be 1, full SHALL be 0, and the state SHALL be PRIME.
REQ-028 Reset asserted mid-sample or mid-playback SHALL discard all partial bytes and FIFO contents; FIFO RAM contents need not be cleared.

Configuration
REQ-029 With macro SAMPLE_BUFFER_UNDERRUN_HOLD_EN defined, mono_sample SHALL hold its last value on underrun; without it, mono_sample SHALL be loaded with 0 on underrun.

Verification
REQ-030 Reset, then send bytes 0x56, 0x34, 0x12 -> fill_level becomes 1 one cycle after the third byte_ready, and the stored entry is 0x123456.
REQ-031 Send bytes 0xAA and 0xBB, wait GAP_CYCLES idle clocks, then send 0x01, 0x02, 0x03 -> the stored entry is 0x030201.
REQ-032 With DEPTH=4, push 2 samples -> playing goes to 1; each sample_req returns the samples in FIFO order on mono_sample one cycle later.
REQ-033 With DEPTH=4, push 5 samples with no sample_req -> full=1, overflow=1, fill_level=4; the fifth sample is absent from the readback.
REQ-034 From PLAY with empty=1, issue sample_req -> underrun pulses 1 cycle, playing=0, and mono_sample is 0 (or the last value with SAMPLE_BUFFER_UNDERRUN_HOLD_EN).
REQ-035 With the FIFO full, issue a push and a sample_req in the same cycle -> the push is accepted, fill_level stays 4, and overflow stays 0.
